ddr_app_ctrl: RTL and testbench

- Bridges the single-beat memory request interface (ren_mem/wen_mem, 64-bit data) to the Xilinx MIG native app interface (128-bit, 8:1 burst).
- Sits directly downstream of the AXI-to-memory slave core and directly upstream of the MIG IP.
- Handles one outstanding request at a time.
- Exposes controller state and handshake observability for the DDR debug pack.

---
 rtl/ddr_app_ctrl_pkg.sv | 32 +++
 rtl/ddr_app_pack.sv | 23 ++
 rtl/ddr_app_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ddr_app_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_app_ctrl_pkg.sv
// Shared types and constants for the MIG app-interface bridge (ddr_app_ctrl).
package DDRCtrlPkg;

  localparam int unsigned REQ_ADDR_W = 64;
  localparam int unsigned MEM_DATA_W = 64;
  localparam int unsigned MEM_MASK_W = 8;
  localparam int unsigned APP_CMD_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_RCMD  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

  localparam logic [APP_CMD_W-1:0] APP_CMD_WRITE = 3'b000;
  localparam logic [APP_CMD_W-1:0] APP_CMD_READ  = 3'b001;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } mem_op_e;

  typedef struct packed {
    mem_op_e                 op;
    logic [REQ_ADDR_W-1:0]   addr;
    logic [MEM_DATA_W-1:0]   wdata;
    logic [MEM_MASK_W-1:0]   wmask;
  } mem_req_t;

endpackage

// File: rtl/ddr_app_pack.sv
// 64->128 write data/mask replication and 128->64 read half-select for one 8:1 burst.
module ddr_app_pack
  import DDRCtrlPkg::*;
(
  input  logic [MEM_DATA_W-1:0]   wdata,
  input  logic [MEM_MASK_W-1:0]   wmask,
  input  logic                    hi_half,
  input  logic [2*MEM_DATA_W-1:0] rd_data,
  output logic [2*MEM_DATA_W-1:0] wdf_data_c,
  output logic [2*MEM_MASK_W-1:0] wdf_mask_c,
  output logic [MEM_DATA_W-1:0]   rd_word_c
);

  assign wdf_data_c = {wdata, wdata};

  // MIG mask is inverted (1 = keep); the unselected half is fully protected
  assign wdf_mask_c = hi_half ? {~wmask, {MEM_MASK_W{1'b1}}}
                              : {{MEM_MASK_W{1'b1}}, ~wmask};

  assign rd_word_c = hi_half ? rd_data[2*MEM_DATA_W-1:MEM_DATA_W]
                             : rd_data[MEM_DATA_W-1:0];

endmodule

// File: rtl/ddr_app_ctrl.sv
// Single-outstanding bridge from the 64-bit memory request port to the MIG native app interface.
// Optional debug observability is built when DDR_CTRL_DEBUG_EN is defined.
module ddr_app_ctrl
  import DDRCtrlPkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned APP_ADDR_W = 28,
  parameter int unsigned APP_DATA_W = 128
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  init_calib_complete,
  input  logic                  ren_mem,
  input  logic                  wen_mem,
  input  logic [ADDR_W-1:0]     addr_mem,
  input  logic [63:0]           wdata_mem,
  input  logic [7:0]            wmask_mem,
  output logic [63:0]           rdata_mem,
  output logic                  rvalid_mem,
  output logic                  wvalid_mem,
  output logic [APP_ADDR_W-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [APP_DATA_W-1:0] app_wdf_data,
  output logic [15:0]           app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  input  logic [APP_DATA_W-1:0] app_rd_data,
  input  logic                  app_rd_data_valid,
  output logic [2:0]            debug_ddrctrl_state,
  output logic [63:0]           debug_visit_times
);

  ctrl_state_e            state_q, state_d;
  mem_req_t               req_q, req_d;
  logic                   cmd_done_q, cmd_done_d;
  logic                   data_done_q, data_done_d;
  logic                   app_en_d, app_wdf_wren_d;
  logic                   rvalid_d, wvalid_d;
  logic [MEM_DATA_W-1:0]  rdata_d;
  logic [MEM_DATA_W-1:0]  rd_word_c;
  logic                   accept_c;
  logic                   cmd_hs_c, data_hs_c;

  assign cmd_hs_c  = app_en && app_rdy;
  assign data_hs_c = app_wdf_wren && app_wdf_rdy;

  // MIG addresses 16-bit columns; align to the 8-column burst holding the request
  assign app_addr    = {req_q.addr[APP_ADDR_W:4], 3'b000};
  assign app_cmd     = (req_q.op == OP_READ) ? APP_CMD_READ : APP_CMD_WRITE;
  assign app_wdf_end = app_wdf_wren;

  ddr_app_pack u_pack (
    .wdata      (req_q.wdata),
    .wmask      (req_q.wmask),
    .hi_half    (req_q.addr[3]),
    .rd_data    (app_rd_data),
    .wdf_data_c (app_wdf_data),
    .wdf_mask_c (app_wdf_mask),
    .rd_word_c  (rd_word_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    cmd_done_d     = cmd_done_q;
    data_done_d    = data_done_q;
    app_en_d       = app_en;
    app_wdf_wren_d = app_wdf_wren;
    rvalid_d       = 1'b0;
    wvalid_d       = 1'b0;
    rdata_d        = rdata_mem;
    accept_c       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (init_calib_complete && (wen_mem || ren_mem)) begin
          accept_c    = 1'b1;
          req_d.op    = wen_mem ? OP_WRITE : OP_READ;
          req_d.addr  = REQ_ADDR_W'(addr_mem);
          req_d.wdata = wdata_mem;
          req_d.wmask = wmask_mem;
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
          app_en_d    = 1'b1;
          if (wen_mem) begin
            app_wdf_wren_d = 1'b1;
            state_d        = ST_WRITE;
          end else begin
            state_d = ST_RCMD;
          end
        end
      end
      ST_WRITE: begin
        // Command and data channels complete independently, in any order
        if (cmd_hs_c) begin
          app_en_d   = 1'b0;
          cmd_done_d = 1'b1;
        end
        if (data_hs_c) begin
          app_wdf_wren_d = 1'b0;
          data_done_d    = 1'b1;
        end
        if ((cmd_done_q || cmd_hs_c) && (data_done_q || data_hs_c)) begin
          wvalid_d = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_RCMD: begin
        if (cmd_hs_c) begin
          app_en_d = 1'b0;
          state_d  = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (app_rd_data_valid) begin
          rdata_d  = rd_word_c;
          rvalid_d = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      cmd_done_q   <= 1'b0;
      data_done_q  <= 1'b0;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      rvalid_mem   <= 1'b0;
      wvalid_mem   <= 1'b0;
      rdata_mem    <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cmd_done_q   <= cmd_done_d;
      data_done_q  <= data_done_d;
      app_en       <= app_en_d;
      app_wdf_wren <= app_wdf_wren_d;
      rvalid_mem   <= rvalid_d;
      wvalid_mem   <= wvalid_d;
      rdata_mem    <= rdata_d;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_q.addr[REQ_ADDR_W-1:APP_ADDR_W+1], req_q.addr[2:0]};

`ifdef DDR_CTRL_DEBUG_EN
  logic [63:0] visit_q;

  // Accepted-request counter, wraps naturally
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      visit_q <= '0;
    end else if (accept_c) begin
      visit_q <= visit_q + 64'd1;
    end
  end

  assign debug_ddrctrl_state = state_q;
  assign debug_visit_times   = visit_q;
`else
  logic unused_accept;
  assign unused_accept       = accept_c;
  assign debug_ddrctrl_state = 3'd0;
  assign debug_visit_times   = 64'd0;
`endif

endmodule

// File: tb/tb_ddr_app_ctrl.sv
// Self-checking bench for ddr_app_ctrl: vector table plus hand sequences, scoreboard on done pulses.
module tb_ddr_app_ctrl;

  logic         clk;
  logic         rstn;
  logic         init_calib_complete;
  logic         ren_mem, wen_mem;
  logic [31:0]  addr_mem;
  logic [63:0]  wdata_mem;
  logic [7:0]   wmask_mem;
  logic [63:0]  rdata_mem;
  logic         rvalid_mem, wvalid_mem;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic [2:0]   debug_ddrctrl_state;
  logic [63:0]  debug_visit_times;

  ddr_app_ctrl dut (
    .clk                 (clk),
    .rstn                (rstn),
    .init_calib_complete (init_calib_complete),
    .ren_mem             (ren_mem),
    .wen_mem             (wen_mem),
    .addr_mem            (addr_mem),
    .wdata_mem           (wdata_mem),
    .wmask_mem           (wmask_mem),
    .rdata_mem           (rdata_mem),
    .rvalid_mem          (rvalid_mem),
    .wvalid_mem          (wvalid_mem),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .debug_ddrctrl_state (debug_ddrctrl_state),
    .debug_visit_times   (debug_visit_times)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_write;
    logic [63:0] rdata;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic         is_write;
    logic [31:0]  addr;
    logic [63:0]  wdata;
    logic [7:0]   wmask;
    logic [127:0] rd_data;
    int           rd_lat;
    logic [27:0]  exp_app_addr;
    logic [15:0]  exp_mask;
    logic [63:0]  exp_rdata;
  } vec_t;
  vec_t vecs[7];

`ifdef DDR_CTRL_DEBUG_EN
  localparam logic [63:0] EXP_VISITS = 64'd3;
`else
  localparam logic [63:0] EXP_VISITS = 64'd0;
`endif

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Done-pulse monitor: each pulse must match the oldest outstanding request
  always @(negedge clk) begin
    sb_t e;
    if (rstn && (rvalid_mem || wvalid_mem)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_pulse: got rvalid=%0b wvalid=%0b expected no pulse", rvalid_mem, wvalid_mem);
      end else begin
        e = sb.pop_front();
        chk("sb_wvalid", wvalid_mem, e.is_write);
        chk("sb_rvalid", rvalid_mem, !e.is_write);
        if (!e.is_write) chk("sb_rdata", rdata_mem, e.rdata);
      end
    end
  end

  // One request with a cycle-accurate MIG model; latencies count app_en cycles before ready
  task automatic run_txn(input logic wr, input logic rd_also, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wmask, input logic [127:0] rdd,
                         input int cmd_lat, input int wdf_lat, input int rd_lat,
                         input logic [27:0] exp_addr, input logic [15:0] exp_mask,
                         input logic [63:0] exp_rdata);
    sb_t  e;
    int   exp_pulse;
    logic got;
    logic exp_en, exp_wren;
    exp_pulse = wr ? (((cmd_lat > wdf_lat) ? cmd_lat : wdf_lat) + 2) : (cmd_lat + 3 + rd_lat);
    got = 1'b0;
    @(negedge clk);
    e.is_write = wr;
    e.rdata    = exp_rdata;
    sb.push_back(e);
    init_calib_complete = 1'b1;
    wen_mem   = wr;
    ren_mem   = rd_also || !wr;
    addr_mem  = addr;
    wdata_mem = wdata;
    wmask_mem = wmask;
    app_rdy   = 1'b0;
    app_wdf_rdy = 1'b0;
    app_rd_data_valid = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      exp_en   = (i <= cmd_lat + 1);
      exp_wren = wr && (i <= wdf_lat + 1);
      chk("app_en", app_en, exp_en);
      chk("app_wdf_wren", app_wdf_wren, exp_wren);
      chk("app_wdf_end", app_wdf_end, exp_wren);
      if (app_en) begin
        chk("app_addr", app_addr, exp_addr);
        chk("app_cmd", app_cmd, wr ? 3'b000 : 3'b001);
      end
      if (app_wdf_wren) begin
        chk("app_wdf_data", app_wdf_data, {wdata, wdata});
        chk("app_wdf_mask", app_wdf_mask, exp_mask);
      end
`ifdef DDR_CTRL_DEBUG_EN
      if (i == 1) chk("debug_state", debug_ddrctrl_state, wr ? 3'd1 : 3'd2);
`endif
      if (rvalid_mem || wvalid_mem) begin
        chk("done_latency", 128'(i), 128'(exp_pulse));
        got = 1'b1;
        break;
      end
      app_rdy     = (i > cmd_lat);
      app_wdf_rdy = (i > wdf_lat);
      app_rd_data_valid = !wr && (i == cmd_lat + 2 + rd_lat);
      app_rd_data = app_rd_data_valid ? rdd : {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL txn_timeout: got no done pulse expected one by cycle %0d", exp_pulse);
    end
    wen_mem = 1'b0;
    ren_mem = 1'b0;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    app_rd_data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0100, 64'h1122_3344_5566_7788, 8'h0F, 128'h0, 0, 28'h0000080, 16'hFFF0, 64'h0};
    vecs[1] = '{1'b1, 32'h0000_0108, 64'hA5A5_0000_FFFF_1234, 8'hA5, 128'h0, 0, 28'h0000080, 16'h5AFF, 64'h0};
    vecs[2] = '{1'b1, 32'h1234_5678, 64'h0F0F_F0F0_0F0F_F0F0, 8'hFF, 128'h0, 0, 28'h91A2B38, 16'h00FF, 64'h0};
    vecs[3] = '{1'b0, 32'h0000_0040, 64'h0, 8'h00,
                {64'hAAAA_AAAA_AAAA_AAAA, 64'h0123_4567_89AB_CDEF}, 0, 28'h0000020, 16'h0, 64'h0123_4567_89AB_CDEF};
    vecs[4] = '{1'b0, 32'h0000_0108, 64'h0, 8'h00,
                {64'hDEAD_BEEF_0000_0001, 64'h0}, 5, 28'h0000080, 16'h0, 64'hDEAD_BEEF_0000_0001};
    vecs[5] = '{1'b0, 32'hFFFF_FFF8, 64'h0, 8'h00,
                {64'hCAFE_F00D_C0DE_0042, 64'h1111_2222_3333_4444}, 2, 28'hFFFFFF8, 16'h0, 64'hCAFE_F00D_C0DE_0042};
    vecs[6] = '{1'b1, 32'h0000_0207, 64'h7766_5544_3322_1100, 8'h00, 128'h0, 0, 28'h0000100, 16'hFFFF, 64'h0};

    rstn = 1'b0;
    init_calib_complete = 1'b0;
    ren_mem = 1'b0;
    wen_mem = 1'b0;
    addr_mem = '0;
    wdata_mem = '0;
    wmask_mem = '0;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    app_rd_data = '0;
    app_rd_data_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_wren", app_wdf_wren, 1'b0);
    chk("rst_rvalid", rvalid_mem, 1'b0);
    chk("rst_wvalid", wvalid_mem, 1'b0);
    chk("rst_rdata", rdata_mem, 64'h0);
    chk("rst_state", debug_ddrctrl_state, 3'd0);
    chk("rst_visits", debug_visit_times, 64'h0);
    rstn = 1'b1;

    // Calibration gate: a held write must not issue until calibration completes
    wen_mem = 1'b1;
    addr_mem = 32'h0000_0300;
    wdata_mem = 64'hFEDC_BA98_7654_3210;
    wmask_mem = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("calib_gate_app_en", app_en, 1'b0);
    end
    run_txn(1'b1, 1'b0, 32'h0000_0300, 64'hFEDC_BA98_7654_3210, 8'h3C, 128'h0, 0, 0, 0,
            28'h0000180, 16'hFFC3, 64'h0);

    for (int v = 0; v < 7; v++) begin
      run_txn(vecs[v].is_write, 1'b0, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, vecs[v].rd_data,
              0, 0, vecs[v].rd_lat, vecs[v].exp_app_addr, vecs[v].exp_mask, vecs[v].exp_rdata);
    end

    // Split handshakes in both orders
    run_txn(1'b1, 1'b0, 32'h0000_0100, 64'h1122_3344_5566_7788, 8'h0F, 128'h0, 0, 3, 0,
            28'h0000080, 16'hFFF0, 64'h0);
    run_txn(1'b1, 1'b0, 32'h0000_0058, 64'h0000_1111_2222_3333, 8'h81, 128'h0, 2, 0, 0,
            28'h0000028, 16'h7EFF, 64'h0);

    // Write wins over a simultaneous read
    run_txn(1'b1, 1'b1, 32'h0000_0010, 64'h5A5A_5A5A_A5A5_A5A5, 8'hFF, 128'h0, 0, 0, 0,
            28'h0000008, 16'hFF00, 64'h0);

    // Read command backpressure for 10 cycles
    run_txn(1'b0, 1'b0, 32'h0000_2008, 64'h0, 8'h00, {64'h0BAD_F00D_1234_5678, 64'h5555_5555_5555_5555},
            10, 0, 1, 28'h0001000, 16'h0, 64'h0BAD_F00D_1234_5678);

    // Reset while waiting for read data
    @(negedge clk);
    ren_mem = 1'b1;
    addr_mem = 32'h0000_0108;
    app_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    app_rdy = 1'b0;
`ifdef DDR_CTRL_DEBUG_EN
    chk("rwait_state", debug_ddrctrl_state, 3'd3);
`endif
    rstn = 1'b0;
    ren_mem = 1'b0;
    #1;
    chk("midrst_state", debug_ddrctrl_state, 3'd0);
    chk("midrst_app_en", app_en, 1'b0);
    chk("midrst_wren", app_wdf_wren, 1'b0);
    chk("midrst_rvalid", rvalid_mem, 1'b0);
    chk("midrst_wvalid", wvalid_mem, 1'b0);
    chk("midrst_rdata", rdata_mem, 64'h0);
    chk("midrst_app_addr", app_addr, 28'h0);
    chk("midrst_app_cmd", app_cmd, 3'b000);
    chk("midrst_visits", debug_visit_times, 64'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Three requests after reset for the visit counter
    run_txn(1'b1, 1'b0, 32'h0000_0000, 64'h0102_0304_0506_0708, 8'hFF, 128'h0, 0, 0, 0,
            28'h0000000, 16'hFF00, 64'h0);
    run_txn(1'b0, 1'b0, 32'h0000_0008, 64'h0, 8'h00, {64'h1357_9BDF_2468_ACE0, 64'h0}, 0, 0, 0,
            28'h0000000, 16'h0, 64'h1357_9BDF_2468_ACE0);
    run_txn(1'b1, 1'b0, 32'h0000_0018, 64'hFFFF_0000_FFFF_0000, 8'h01, 128'h0, 1, 1, 0,
            28'h0000008, 16'hFEFF, 64'h0);
    @(negedge clk);
    chk("visit_times", debug_visit_times, EXP_VISITS);
    chk("sb_drained", 128'(sb.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
